// File: rtl/mips_multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_multicycle_ctrl_if
//  Description : Controller <-> datapath bundle for the multi-cycle MIPS core.
//                Carries the decoded IR fields and zero flag towards the
//                controller and every mux select / strobe / ALU control back.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mips_multicycle_ctrl_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               zero;
    logic               pc_en;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         pc_source;
    logic [1:0]         alu_op;
    logic               alu_binv;
    logic               alu_cin;
    logic               illegal;
    logic [STATE_W-1:0] state;

    // Controller side
    modport master (
        input  opcode, funct, zero,
        output pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
               alu_op, alu_binv, alu_cin, illegal, state
    );

    // Datapath side
    modport slave (
        output opcode, funct, zero,
        input  pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
               alu_op, alu_binv, alu_cin, illegal, state
    );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mips_multicycle_ctrl
//  Description : Moore control FSM for the multi-cycle MIPS datapath
//                (fetch / decode / execute / memory / writeback).
//                Optional macro ADDI_EN adds addi support (states 10, 11).
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  wire logic               clk,
    input  wire logic               reset,
    mips_multicycle_ctrl_if.master  bus
);

    localparam logic [STATE_W-1:0] c_ST_FETCH   = STATE_W'(0);
    localparam logic [STATE_W-1:0] c_ST_DECODE  = STATE_W'(1);
    localparam logic [STATE_W-1:0] c_ST_MEMADR  = STATE_W'(2);
    localparam logic [STATE_W-1:0] c_ST_MEMRD   = STATE_W'(3);
    localparam logic [STATE_W-1:0] c_ST_MEMWB   = STATE_W'(4);
    localparam logic [STATE_W-1:0] c_ST_MEMWR   = STATE_W'(5);
    localparam logic [STATE_W-1:0] c_ST_EXEC    = STATE_W'(6);
    localparam logic [STATE_W-1:0] c_ST_RWB     = STATE_W'(7);
    localparam logic [STATE_W-1:0] c_ST_BRANCH  = STATE_W'(8);
    localparam logic [STATE_W-1:0] c_ST_JUMP    = STATE_W'(9);
`ifdef ADDI_EN
    localparam logic [STATE_W-1:0] c_ST_ADDI_EX = STATE_W'(10);
    localparam logic [STATE_W-1:0] c_ST_ADDI_WB = STATE_W'(11);
    localparam logic [5:0]         c_OP_ADDI    = 6'b001000;
`endif

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_FN_ADD   = 6'b100000;
    localparam logic [5:0] c_FN_SUB   = 6'b100010;
    localparam logic [5:0] c_FN_AND   = 6'b100100;
    localparam logic [5:0] c_FN_OR    = 6'b100101;

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    logic               w_funct_ok;
    logic               w_op_legal;
    logic               w_pc_write;
    logic               w_pc_write_cond;

    // Only the four supported ALU functs make an R-type instruction legal
    assign w_funct_ok = (bus.funct == c_FN_ADD) || (bus.funct == c_FN_SUB) ||
                        (bus.funct == c_FN_AND) || (bus.funct == c_FN_OR);

    // Instruction recognition used both for DECODE dispatch and the illegal pulse
    always_comb begin
        w_op_legal = 1'b0;
        case (bus.opcode)
            c_OP_LW, c_OP_SW, c_OP_BEQ, c_OP_J: w_op_legal = 1'b1;
            c_OP_RTYPE:                         w_op_legal = w_funct_ok;
`ifdef ADDI_EN
            c_OP_ADDI:                          w_op_legal = 1'b1;
`endif
            default:                            w_op_legal = 1'b0;
        endcase
    end

    // State register: reset returns to FETCH, abandoning any instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; every instruction (and unused encodings) ends in FETCH
    always_comb begin
        w_next = c_ST_FETCH;
        case (r_state)
            c_ST_FETCH:  w_next = c_ST_DECODE;
            c_ST_DECODE: begin
                case (bus.opcode)
                    c_OP_LW, c_OP_SW: w_next = c_ST_MEMADR;
                    c_OP_RTYPE:       w_next = w_funct_ok ? c_ST_EXEC : c_ST_FETCH;
                    c_OP_BEQ:         w_next = c_ST_BRANCH;
                    c_OP_J:           w_next = c_ST_JUMP;
`ifdef ADDI_EN
                    c_OP_ADDI:        w_next = c_ST_ADDI_EX;
`endif
                    default:          w_next = c_ST_FETCH;
                endcase
            end
            c_ST_MEMADR: w_next = (bus.opcode == c_OP_SW) ? c_ST_MEMWR : c_ST_MEMRD;
            c_ST_MEMRD:  w_next = c_ST_MEMWB;
            c_ST_EXEC:   w_next = c_ST_RWB;
`ifdef ADDI_EN
            c_ST_ADDI_EX: w_next = c_ST_ADDI_WB;
`endif
            default:     w_next = c_ST_FETCH;
        endcase
    end

    // Output decode of the state register; everything held low during reset
    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        bus.i_or_d      = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.ir_write    = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.reg_write   = 1'b0;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = 2'b00;
        bus.pc_source   = 2'b00;
        bus.alu_op      = 2'b00;
        bus.alu_binv    = 1'b0;
        bus.alu_cin     = 1'b0;
        bus.illegal     = 1'b0;
        if (!reset) begin
            case (r_state)
                c_ST_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.ir_write  = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.alu_op    = 2'b10;
                    w_pc_write    = 1'b1;
                end
                c_ST_DECODE: begin
                    bus.alu_src_b = 2'b11;
                    bus.alu_op    = 2'b10;
                    bus.illegal   = ~w_op_legal;
                end
                c_ST_MEMADR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    bus.alu_op    = 2'b10;
                end
                c_ST_MEMRD: begin
                    bus.mem_read = 1'b1;
                    bus.i_or_d   = 1'b1;
                end
                c_ST_MEMWB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                end
                c_ST_MEMWR: begin
                    bus.mem_write = 1'b1;
                    bus.i_or_d    = 1'b1;
                end
                c_ST_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    case (bus.funct)
                        c_FN_SUB: begin
                            bus.alu_op   = 2'b10;
                            bus.alu_binv = 1'b1;
                            bus.alu_cin  = 1'b1;
                        end
                        c_FN_AND: bus.alu_op = 2'b00;
                        c_FN_OR:  bus.alu_op = 2'b01;
                        default:  bus.alu_op = 2'b10;
                    endcase
                end
                c_ST_RWB: begin
                    bus.reg_dst   = 1'b1;
                    bus.reg_write = 1'b1;
                end
                c_ST_BRANCH: begin
                    bus.alu_src_a   = 1'b1;
                    bus.alu_op      = 2'b10;
                    bus.alu_binv    = 1'b1;
                    bus.alu_cin     = 1'b1;
                    w_pc_write_cond = 1'b1;
                    bus.pc_source   = 2'b01;
                end
                c_ST_JUMP: begin
                    w_pc_write    = 1'b1;
                    bus.pc_source = 2'b10;
                end
`ifdef ADDI_EN
                c_ST_ADDI_EX: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    bus.alu_op    = 2'b10;
                end
                c_ST_ADDI_WB: begin
                    bus.reg_write = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    // PC enable follows zero combinationally so beq resolves within BRANCH
    assign bus.pc_en = w_pc_write | (w_pc_write_cond & bus.zero);
    assign bus.state = reset ? '0 : r_state;

endmodule
`default_nettype wire
